// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: state encoding and sizing constants used by the
// key-scheduling FSM and the decoder FSM.
package rc4_pkg;

  localparam int KEY_LEN = 3;
  localparam int S_SIZE = 256;
  localparam int KEY_IDX_W = 2;
  localparam logic [7:0] LAST_IDX = 8'(S_SIZE - 1);
  localparam logic [KEY_IDX_W-1:0] LAST_KEY_IDX = KEY_IDX_W'(KEY_LEN - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    INIT_WR = 4'd1,
    RD_I    = 4'd2,
    WAIT_I  = 4'd3,
    CALC_J  = 4'd4,
    RD_J    = 4'd5,
    WAIT_J  = 4'd6,
    WR_J    = 4'd7,
    WR_I    = 4'd8,
    NEXT    = 4'd9,
    DONE    = 4'd10
  } ksa_state_t;

endpackage

// File: rtl/ksa_key_sel.sv
// Maps the rolling key index onto a byte of the secret key; byte 0 is the
// most significant byte of the key word.
module ksa_key_sel
  import rc4_pkg::*;
(
  input  logic [8*KEY_LEN-1:0] secret_key,
  input  logic [KEY_IDX_W-1:0] key_idx,
  output logic [7:0]           key_byte
);

  // Byte select; out-of-range indices give zero rather than X.
  always_comb begin
    key_byte = 8'd0;
    case (key_idx)
      2'd0:    key_byte = secret_key[23:16];
      2'd1:    key_byte = secret_key[15:8];
      2'd2:    key_byte = secret_key[7:0];
      default: key_byte = 8'd0;
    endcase
  end

endmodule

// File: rtl/ksa_fsm.sv
// RC4 key-scheduling FSM: fills S-RAM with the identity permutation, then
// performs the keyed swap pass through a 1-cycle-latency synchronous RAM.
module ksa_fsm
  import rc4_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [8*KEY_LEN-1:0] secret_key,
  input  logic [7:0]           data_in,
  output logic [7:0]           address,
  output logic [7:0]           data_out,
  output logic                 write_enable,
  output logic                 done
);

  ksa_state_t state_r, state_s;
  logic [7:0] i_r, i_s;
  logic [7:0] j_r, j_s;
  logic [7:0] si_r, si_s;
  logic [7:0] sj_r, sj_s;
  logic [KEY_IDX_W-1:0] key_idx_r, key_idx_s;
  logic [7:0] key_byte_s;
  logic [7:0] address_s, data_out_s;
  logic write_enable_s, done_s;

  ksa_key_sel u_key_sel (
    .secret_key (secret_key),
    .key_idx    (key_idx_r),
    .key_byte   (key_byte_s)
  );

  // Next-state and datapath update.
  always_comb begin
    state_s   = state_r;
    i_s       = i_r;
    j_s       = j_r;
    si_s      = si_r;
    sj_s      = sj_r;
    key_idx_s = key_idx_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s   = INIT_WR;
          i_s       = 8'd0;
          j_s       = 8'd0;
          key_idx_s = '0;
        end else begin
          state_s = state_r;
        end
      end
      INIT_WR: begin
        if (i_r == LAST_IDX) begin
          state_s = RD_I;
          i_s     = 8'd0;
        end else begin
          i_s = i_r + 8'd1;
        end
      end
      RD_I:   state_s = WAIT_I;
      WAIT_I: begin
        si_s    = data_in;
        state_s = CALC_J;
      end
      CALC_J: begin
        j_s     = j_r + si_r + key_byte_s;
        state_s = RD_J;
      end
      RD_J:   state_s = WAIT_J;
      WAIT_J: begin
        sj_s    = data_in;
        state_s = WR_J;
      end
      WR_J:   state_s = WR_I;
      WR_I:   state_s = NEXT;
      NEXT: begin
        if (i_r == LAST_IDX) begin
          state_s = DONE;
        end else begin
          state_s   = RD_I;
          i_s       = i_r + 8'd1;
          // Wrap counter keeps the key index in step with i without a divider.
          key_idx_s = (key_idx_r == LAST_KEY_IDX) ? '0 : key_idx_r + 2'd1;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered
  // and still line up with the cycle of the state they belong to.
  always_comb begin
    address_s      = address;
    data_out_s     = data_out;
    write_enable_s = 1'b0;
    done_s         = 1'b0;
    case (state_s)
      INIT_WR: begin
        address_s      = i_s;
        data_out_s     = i_s;
        write_enable_s = 1'b1;
      end
      RD_I, WAIT_I: address_s = i_s;
      RD_J, WAIT_J: address_s = j_s;
      WR_J: begin
        address_s      = j_s;
        data_out_s     = si_s;
        write_enable_s = 1'b1;
      end
      WR_I: begin
        address_s      = i_s;
        data_out_s     = sj_s;
        write_enable_s = 1'b1;
      end
      DONE:    done_s = 1'b1;
      default: done_s = 1'b0;
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      i_r          <= 8'd0;
      j_r          <= 8'd0;
      si_r         <= 8'd0;
      sj_r         <= 8'd0;
      key_idx_r    <= '0;
      address      <= 8'd0;
      data_out     <= 8'd0;
      write_enable <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_r      <= state_s;
      i_r          <= i_s;
      j_r          <= j_s;
      si_r         <= si_s;
      sj_r         <= sj_s;
      key_idx_r    <= key_idx_s;
      address      <= address_s;
      data_out     <= data_out_s;
      write_enable <= write_enable_s;
      done         <= done_s;
    end
  end

endmodule
